div_seq: RTL and testbench
==========================

# div_seq

Sequential restoring divider for the ALU datapath: the inverse operation to the carry-lookahead adder chain. It accepts a dividend/divisor pair on a start pulse and retires one quotient bit per cycle using a shared subtract stage. It returns quotient and remainder with a one-cycle done pulse. It sits beside the adder in the execute stage and stalls the pipeline via busy.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- dividend  input  WIDTH  sampled with start
- divisor  input  WIDTH  sampled with start
- busy  output  1  high in PREP/ITER/FIX
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  held from done until next accepted start
- remainder  output  WIDTH  held as quotient
- div_by_zero  output  1  set with done when divisor == 0, held as quotient

## Operation
- States: IDLE → PREP → ITER (WIDTH cycles) → FIX → DONE → IDLE.
- IDLE: start=1 latches operands and signed_op, goes to PREP. Start in any other state is ignored; operands are not re-sampled.
- PREP:
  - divisor == 0 → quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, go directly to DONE.
  - Otherwise: record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both only when signed_op. Convert the operands to magnitudes; the magnitude of the most-negative value is 2^(WIDTH-1) as unsigned. Clear the partial remainder and the iteration counter.
- ITER, per cycle:
  - Shift {rem, quo} left 1, bringing in the dividend MSB.
  - trial = rem − divisor_mag (WIDTH+1 bits).
  - trial non-negative → rem = trial, quo LSB = 1; else keep rem, LSB = 0.
  - Counter 0..WIDTH−1; leave ITER after count WIDTH−1.
- FIX: negate quo if sign_q; negate rem if sign_r (truncating division; remainder takes the dividend's sign). Register the outputs.
- DONE: done = 1 for this cycle only, then IDLE.
- Overflow case: most-negative / −1 yields quotient = most-negative, remainder = 0, with no flag. This falls out of the magnitude arithmetic modulo 2^WIDTH.
- div_by_zero is cleared on the next accepted start.

## Timing
- Cycle 0: start high at an edge in IDLE. Cycle 1: PREP. Cycles 2..WIDTH+1: ITER. Cycle WIDTH+2: FIX. Cycle WIDTH+3: DONE with done = 1; that is cycle 35 for WIDTH = 32.
- Divide-by-zero: PREP in cycle 1, DONE in cycle 2.
- busy rises the cycle after start is accepted and falls as DONE is entered. busy and done are never both high.
- Back-to-back: the earliest next start is accepted in the cycle after DONE, when the block is back in IDLE.
- Reset: state IDLE. busy, done, div_by_zero, quotient and remainder all read 0 in the cycle after rst is sampled high. rst mid-operation aborts with the same values; no done is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined: signed_op is honoured, and the sign capture, magnitude conversion and FIX negation logic are present.
- DIV_SIGNED_EN undefined: signed_op is ignored, and every operation is unsigned. FIX still exists as a one-cycle pass-through, so latency is identical in both builds.

## Structure
- Package div_pkg: state enum (S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE), default WIDTH constant, counter width constant $clog2(WIDTH).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, next dividend bit, divisor_mag.
  - Outputs: new rem, quotient bit.
  - Built on a WIDTH+1-bit subtract, implemented as a + ~b + 1 through the team's carry-lookahead adder.
- Top div_seq holds the FSM, counter, shift registers and sign fix-up.

## Test plan
All cases use WIDTH = 32.
- Unsigned 100 / 7, start in cycle 0 → done in cycle 35 only, quotient = 14, remainder = 2, div_by_zero = 0; busy high in cycles 1–34.
- 0x00001234 / 0 → done in cycle 2, quotient = 0xFFFFFFFF, remainder = 0x00001234, div_by_zero = 1.
- Signed −7 / 2 (0xFFFFFFF9, 0x2), with DIV_SIGNED_EN → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1).
- Signed 0x80000000 / 0xFFFFFFFF, with DIV_SIGNED_EN → quotient = 0x80000000, remainder = 0, div_by_zero = 0.
- Start 1000 / 10. Pulse start with 5 / 1 in cycle 10 → ignored; result is quotient = 100, remainder = 0. On a second run, rst in cycle 20 → cycle 21 has busy = 0 and all outputs 0; no done follows.
- DIV_SIGNED_EN undefined, signed_op = 1, 0xFFFFFFF9 / 2 → quotient = 0x7FFFFFFC, remainder = 1, done in cycle 35.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The states are S_IDLE, S_PREP, S_ITER, S_FIX and S_DONE.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// Single restoring-division step. It shifts the next dividend bit into the
// partial remainder, then does a trial subtract of a + ~b + 1 on WIDTH+1 bits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   b_inv;
  logic [WIDTH:0]   gen;
  logic [WIDTH:0]   prop;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] carry;

  assign shifted  = {rem, dvd_bit};
  assign b_inv    = ~{1'b0, divisor_mag};
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi <= WIDTH; gi++) begin : g_bit
      assign gen[gi]       = shifted[gi] & b_inv[gi];
      assign prop[gi]      = shifted[gi] ^ b_inv[gi];
      assign carry[gi + 1] = gen[gi] | (prop[gi] & carry[gi]);
      assign trial[gi]     = prop[gi] ^ carry[gi];
    end
  endgenerate

  // If there is a carry out of the subtract, there was no borrow, so the trial remainder is non-negative.
  assign q_bit    = carry[WIDTH+1];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider that retires one quotient bit per cycle.
// Signed operation is compiled in only when the DIV_SIGNED_EN macro is defined.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dividend_reg, divisor_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_mag_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             busy_reg, done_reg, dbz_reg;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic             div_zero, last_iter;

  assign div_zero  = (divisor_reg == '0);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  logic signed_reg, sign_q_reg, sign_r_reg;
  logic neg_dvd, neg_dvs;

  assign neg_dvd = signed_reg & dividend_reg[WIDTH-1];
  assign neg_dvs = signed_reg & divisor_reg[WIDTH-1];
  // Two's-complement negation of the most-negative value yields 2^(WIDTH-1) as unsigned.
  assign dvd_mag = neg_dvd ? (~dividend_reg + WIDTH'(1)) : dividend_reg;
  assign dvs_mag = neg_dvs ? (~divisor_reg + WIDTH'(1)) : divisor_reg;
  assign quo_fix = sign_q_reg ? (~quo_reg + WIDTH'(1)) : quo_reg;
  assign rem_fix = sign_r_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      signed_reg <= 1'b0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
    end else if (state_reg == S_IDLE && start) begin
      signed_reg <= signed_op;
    end else if (state_reg == S_PREP) begin
      sign_q_reg <= neg_dvd ^ neg_dvs;
      sign_r_reg <= neg_dvd;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend_reg;
  assign dvs_mag = divisor_reg;
  assign quo_fix = quo_reg;
  assign rem_fix = rem_reg;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_reg),
    .dvd_bit     (quo_reg[WIDTH-1]),
    .divisor_mag (dvs_mag_reg),
    .rem_next    (rem_step),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_PREP;
      S_PREP: state_next = div_zero ? S_DONE : S_ITER;
      S_ITER: if (last_iter) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_mag_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            dbz_reg      <= 1'b0;
          end
        end
        S_PREP: begin
          if (div_zero) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg;
            dbz_reg       <= 1'b1;
          end else begin
            rem_reg     <= '0;
            quo_reg     <= dvd_mag;
            dvs_mag_reg <= dvs_mag;
            cnt_reg     <= '0;
          end
        end
        S_ITER: begin
          // quo_reg doubles as the dividend shifter: its MSB feeds the step as quotient bits fill the LSB.
          rem_reg <= rem_step;
          quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        S_FIX: begin
          quotient_reg  <= quo_fix;
          remainder_reg <= rem_fix;
        end
        default: ;
      endcase
      busy_reg <= (state_next == S_PREP) || (state_next == S_ITER) || (state_next == S_FIX);
      done_reg <= (state_next == S_DONE);
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at WIDTH = 32.
// Signed expectations follow whether DIV_SIGNED_EN is defined.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_vec = 0;
  int n_fail = 0;

  int          obs_done_cnt, obs_done_cyc, obs_busy_first, obs_busy_last, obs_overlap;
  logic [31:0] obs_q, obs_r;
  logic        obs_z;
  logic        snap_busy, snap_done, snap_z;
  logic [31:0] snap_q, snap_r;

  div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Called at a negedge. Start is held across edge 0 and the loop samples at the negedge inside each cycle.
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        input int window, input int inj_cyc, input int rst_cyc);
    obs_done_cnt = 0; obs_done_cyc = -1; obs_busy_first = -1; obs_busy_last = -1;
    obs_overlap = 0; obs_q = '0; obs_r = '0; obs_z = 1'b0;
    snap_busy = 1'b1; snap_done = 1'b1; snap_z = 1'b1; snap_q = '1; snap_r = '1;
    start = 1'b1; signed_op = sop; dividend = a; divisor = b;
    @(negedge clk);
    for (int c = 1; c <= window; c++) begin
      if (busy) begin
        if (obs_busy_first < 0) obs_busy_first = c;
        obs_busy_last = c;
      end
      if (busy && done) obs_overlap++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c; obs_q = quotient; obs_r = remainder; obs_z = div_by_zero;
        end
      end
      if (rst_cyc >= 0 && c == rst_cyc + 1) begin
        snap_busy = busy; snap_done = done; snap_z = div_by_zero; snap_q = quotient; snap_r = remainder;
      end
      if (c == inj_cyc) begin
        start = 1'b1; dividend = 32'd5; divisor = 32'd1;
      end else begin
        start = 1'b0;
      end
      rst = (c == rst_cyc);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;
    $display("op sop=%0b %h / %h -> q=%h r=%h dbz=%0b done_cyc=%0d done_cnt=%0d",
             sop, a, b, obs_q, obs_r, obs_z, obs_done_cyc, obs_done_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient got %h want 0", quotient); end
    n_vec++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", remainder); end
    n_vec++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
    $display("reset applied and released");
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 32'd100, 32'd7, 40, -1, -1);
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL u_done_cyc got %0d want 35", obs_done_cyc); end
    n_vec++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL u_done_cnt got %0d want 1", obs_done_cnt); end
    n_vec++; if (obs_q !== 32'd14) begin n_fail++; $display("FAIL u_quotient got %h want 0000000e", obs_q); end
    n_vec++; if (obs_r !== 32'd2) begin n_fail++; $display("FAIL u_remainder got %h want 00000002", obs_r); end
    n_vec++; if (obs_z !== 1'b0) begin n_fail++; $display("FAIL u_dbz got %b want 0", obs_z); end
    n_vec++; if (obs_busy_first != 1) begin n_fail++; $display("FAIL u_busy_first got %0d want 1", obs_busy_first); end
    n_vec++; if (obs_busy_last != 34) begin n_fail++; $display("FAIL u_busy_last got %0d want 34", obs_busy_last); end
    n_vec++; if (obs_overlap != 0) begin n_fail++; $display("FAIL u_busy_done_overlap got %0d want 0", obs_overlap); end
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 32'h0000_1234, 32'h0, 6, -1, -1);
    n_vec++; if (obs_done_cyc != 2) begin n_fail++; $display("FAIL z_done_cyc got %0d want 2", obs_done_cyc); end
    n_vec++; if (obs_q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z_quotient got %h want ffffffff", obs_q); end
    n_vec++; if (obs_r !== 32'h0000_1234) begin n_fail++; $display("FAIL z_remainder got %h want 00001234", obs_r); end
    n_vec++; if (obs_z !== 1'b1) begin n_fail++; $display("FAIL z_dbz got %b want 1", obs_z); end
    n_vec++; if (obs_busy_last != 1) begin n_fail++; $display("FAIL z_busy_last got %0d want 1", obs_busy_last); end
    n_vec++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL z_dbz_held got %b want 1", div_by_zero); end
  endtask

  task automatic test_signed();
    logic [31:0] exp_q, exp_r;
`ifdef DIV_SIGNED_EN
    exp_q = 32'hFFFF_FFFD; exp_r = 32'hFFFF_FFFF;
`else
    exp_q = 32'h7FFF_FFFC; exp_r = 32'h0000_0001;
`endif
    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 40, -1, -1);
    n_vec++; if (obs_q !== exp_q) begin n_fail++; $display("FAIL s_m7_q got %h want %h", obs_q, exp_q); end
    n_vec++; if (obs_r !== exp_r) begin n_fail++; $display("FAIL s_m7_r got %h want %h", obs_r, exp_r); end
    n_vec++; if (obs_z !== 1'b0) begin n_fail++; $display("FAIL s_m7_dbz_cleared got %b want 0", obs_z); end
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL s_m7_done_cyc got %0d want 35", obs_done_cyc); end

`ifdef DIV_SIGNED_EN
    exp_q = 32'h8000_0000; exp_r = 32'h0;
`else
    exp_q = 32'h0; exp_r = 32'h8000_0000;
`endif
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 40, -1, -1);
    n_vec++; if (obs_q !== exp_q) begin n_fail++; $display("FAIL s_ovf_q got %h want %h", obs_q, exp_q); end
    n_vec++; if (obs_r !== exp_r) begin n_fail++; $display("FAIL s_ovf_r got %h want %h", obs_r, exp_r); end
    n_vec++; if (obs_z !== 1'b0) begin n_fail++; $display("FAIL s_ovf_dbz got %b want 0", obs_z); end

`ifdef DIV_SIGNED_EN
    exp_q = 32'hFFFF_FFFD; exp_r = 32'h1;
`else
    exp_q = 32'h0; exp_r = 32'h7;
`endif
    run_op(1'b1, 32'h7, 32'hFFFF_FFFE, 40, -1, -1);
    n_vec++; if (obs_q !== exp_q) begin n_fail++; $display("FAIL s_negdvs_q got %h want %h", obs_q, exp_q); end
    n_vec++; if (obs_r !== exp_r) begin n_fail++; $display("FAIL s_negdvs_r got %h want %h", obs_r, exp_r); end
  endtask

  task automatic test_unsigned_op_flag_off();
    run_op(1'b0, 32'hFFFF_FFF9, 32'h2, 40, -1, -1);
    n_vec++; if (obs_q !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL uo_q got %h want 7ffffffc", obs_q); end
    n_vec++; if (obs_r !== 32'h1) begin n_fail++; $display("FAIL uo_r got %h want 00000001", obs_r); end
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL uo_done_cyc got %0d want 35", obs_done_cyc); end
  endtask

  task automatic test_ignored_start();
    run_op(1'b0, 32'd1000, 32'd10, 40, 10, -1);
    n_vec++; if (obs_q !== 32'd100) begin n_fail++; $display("FAIL ign_q got %h want 00000064", obs_q); end
    n_vec++; if (obs_r !== 32'd0) begin n_fail++; $display("FAIL ign_r got %h want 00000000", obs_r); end
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL ign_done_cyc got %0d want 35", obs_done_cyc); end
    n_vec++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d want 1", obs_done_cnt); end
  endtask

  task automatic test_abort();
    run_op(1'b0, 32'd1000, 32'd10, 45, -1, 20);
    n_vec++; if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", snap_busy); end
    n_vec++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", snap_done); end
    n_vec++; if (snap_q !== 32'h0) begin n_fail++; $display("FAIL abort_q got %h want 0", snap_q); end
    n_vec++; if (snap_r !== 32'h0) begin n_fail++; $display("FAIL abort_r got %h want 0", snap_r); end
    n_vec++; if (snap_z !== 1'b0) begin n_fail++; $display("FAIL abort_dbz got %b want 0", snap_z); end
    n_vec++; if (obs_done_cnt != 0) begin n_fail++; $display("FAIL abort_done_cnt got %0d want 0", obs_done_cnt); end
    n_vec++; if (obs_busy_last != 20) begin n_fail++; $display("FAIL abort_busy_last got %0d want 20", obs_busy_last); end
  endtask

  task automatic test_back_to_back();
    // A window of 35 ends at the negedge of cycle 36, so the second start is taken on the edge right after DONE.
    run_op(1'b0, 32'd100, 32'd7, 35, -1, -1);
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL b2b_first_done got %0d want 35", obs_done_cyc); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 40, -1, -1);
    n_vec++; if (obs_done_cyc != 35) begin n_fail++; $display("FAIL b2b_second_done got %0d want 35", obs_done_cyc); end
    n_vec++; if (obs_q !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL b2b_q got %h want 0fffffff", obs_q); end
    n_vec++; if (obs_r !== 32'hF) begin n_fail++; $display("FAIL b2b_r got %h want 0000000f", obs_r); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_unsigned_op_flag_off();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
